// File: rtl/lsu_ctrl_pkg.sv
// Core-wide memory access definitions: funct3 size encodings, fault causes, LSU states.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package lsu_ctrl_pkg;

  // funct3 encodings for load/store access size
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // fault cause codes reported alongside mem_exc
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BADSIZE  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3,
    S_HALT = 3'd4
  } lsu_state_e;

  // true for sizes that only make sense on a load (unsigned variants)
  function automatic logic is_unsigned_size(input logic [2:0] size);
    return size[2];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and size/alignment checks.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      size,
  input  logic [1:0]      off,
  input  logic            store,
  input  logic [XLEN-1:0] wdata_raw,
  input  logic [2:0]      ld_size,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata_raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign,
  output logic            badsize
);

  logic [XLEN-1:0] rd_shift;

  // request side: byte enables, replicated store data and legality flags
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata_raw;
    misalign  = 1'b0;
    badsize   = 1'b0;
    case (size)
      MEM_B, MEM_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata_raw[7:0]}};
      end
      MEM_H, MEM_HU: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata_raw[15:0]}};
        misalign  = off[0];
      end
      MEM_W: begin
        be        = 4'b1111;
        misalign  = (off != 2'b00);
      end
      default: badsize = 1'b1;
    endcase
    // unsigned variants have no store counterpart
    if (store && is_unsigned_size(size)) begin
      badsize = 1'b1;
    end
  end

  assign rd_shift = rdata_raw >> {ld_off, 3'b000};

  // response side: pick the addressed lanes and extend to full width
  always_comb begin
    rdata_ext = rdata_raw;
    case (ld_size)
      MEM_B:   rdata_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_BU:  rdata_ext = {24'h000000, rd_shift[7:0]};
      MEM_H:   rdata_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_HU:  rdata_ext = {16'h0000, rd_shift[15:0]};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between MEM stage and a req/ack data bus, with fault and halt sequencing.
// Latency: >=2 stall cycles per access (ack in first REQ cycle); result valid 1 cycle after ack.
// Backpressure: bus_req held until bus_ack; pipeline stalled for the whole access or forever once halted.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            memtoreg,
  input  logic            memwrite,
  input  logic [2:0]      memsize,
  input  logic            hlt,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            mem_exc,
  output logic [1:0]      exc_cause,
  output logic            halted,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  lsu_state_e      state;
  logic            access;
  logic            stall_q;
  logic [2:0]      op_size;
  logic [1:0]      op_off;
  logic            op_load;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic [3:0]      a_be;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_rdata;
  logic            a_misalign;
  logic            a_badsize;

  assign access  = mem_valid & (memtoreg | memwrite);
  assign cnt_inc = cnt + CNT_W'(1);

  // IDLE must freeze the pipeline in the same cycle the access is seen
  assign stall = stall_q | ((state == S_IDLE) & access);

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .size      (memsize),
    .off       (addr[1:0]),
    .store     (memwrite),
    .wdata_raw (wdata),
    .ld_size   (op_size),
    .ld_off    (op_off),
    .rdata_raw (bus_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .rdata_ext (a_rdata),
    .misalign  (a_misalign),
    .badsize   (a_badsize)
  );

  // sequencer: state, latched request, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      stall_q     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'b0000;
      bus_wdata   <= '0;
      op_size     <= MEM_B;
      op_off      <= 2'b00;
      op_load     <= 1'b0;
      cnt         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_exc     <= 1'b0;
      exc_cause   <= EXC_NONE;
      halted      <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      mem_exc     <= 1'b0;
      exc_cause   <= EXC_NONE;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (a_badsize || a_misalign) begin
              // bad size wins: alignment is meaningless for an undefined size
              state     <= S_ERR;
              mem_exc   <= 1'b1;
              exc_cause <= a_badsize ? EXC_BADSIZE : EXC_MISALIGN;
            end else begin
              state     <= S_REQ;
              stall_q   <= 1'b1;
              bus_req   <= 1'b1;
              bus_we    <= memwrite;
              bus_addr  <= {addr[XLEN-1:2], 2'b00};
              bus_be    <= a_be;
              bus_wdata <= a_wdata;
              op_size   <= memsize;
              op_off    <= addr[1:0];
              op_load   <= memtoreg;
              cnt       <= '0;
            end
          end else if (hlt) begin
            state   <= S_HALT;
            stall_q <= 1'b1;
            halted  <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            state       <= S_DONE;
            stall_q     <= 1'b0;
            bus_req     <= 1'b0;
            rdata_valid <= op_load;
            if (op_load) begin
              rdata <= a_rdata;
            end
          end else if ((TIMEOUT != 0) && (cnt_inc == TO_LIMIT)) begin
            state     <= S_ERR;
            stall_q   <= 1'b0;
            bus_req   <= 1'b0;
            mem_exc   <= 1'b1;
            exc_cause <= EXC_TIMEOUT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, faults, watchdog, halt and async reset.
// Latency: checks stall length per access and result timing one cycle after ack.
// Backpressure: bus ack delay is driven per vector.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        memtoreg;
  logic        memwrite;
  logic [2:0]  memsize;
  logic        hlt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mem_exc;
  logic [1:0]  exc_cause;
  logic        halted;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks;
  int errors;

  // values observed by run_op
  int          stall_cnt;
  int          req_cnt;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        o_rvld;
  logic [31:0] o_rdata;
  logic        o_exc;
  logic [1:0]  o_cause;
  logic        o_exc_after;

  lsu_ctrl #(
    .XLEN    (32),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_valid   (mem_valid),
    .memtoreg    (memtoreg),
    .memwrite    (memwrite),
    .memsize     (memsize),
    .hlt         (hlt),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_exc     (mem_exc),
    .exc_cause   (exc_cause),
    .halted      (halted),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 1'b0;
    memtoreg  = 1'b0;
    memwrite  = 1'b0;
    memsize   = 3'b000;
    hlt       = 1'b0;
    addr      = '0;
    wdata     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
  endtask

  // Present one access, ack after 'waits' REQ cycles, capture what the DUT shows.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd);
    int n;
    int w;
    mem_valid = 1'b1;
    memtoreg  = ld;
    memwrite  = st;
    memsize   = sz;
    addr      = a;
    wdata     = wd;
    #1;
    stall_cnt = 0;
    req_cnt   = 0;
    s_we = 1'b0; s_be = 4'h0; s_addr = '0; s_wdata = '0;
    n = 0;
    w = 0;
    while (stall && n < 40) begin
      stall_cnt++;
      if (bus_req) begin
        if (req_cnt == 0) begin
          s_we    = bus_we;
          s_be    = bus_be;
          s_addr  = bus_addr;
          s_wdata = bus_wdata;
        end
        req_cnt++;
      end
      bus_ack   = bus_req && (w == waits);
      bus_rdata = rd;
      if (bus_req) w++;
      tick();
      bus_ack = 1'b0;
      n++;
    end
    if (n >= 40) begin
      check("stall_bound", 32'(n), 32'(39));
    end
    o_rvld  = rdata_valid;
    o_rdata = rdata;
    o_exc   = mem_exc;
    o_cause = exc_cause;
    mem_valid = 1'b0;
    memtoreg  = 1'b0;
    memwrite  = 1'b0;
    tick();
    o_exc_after = mem_exc;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    // reset state
    check("rst_stall",  32'(stall), 32'd0);
    check("rst_busreq", 32'(bus_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_exc",    {29'd0, mem_exc, exc_cause}, 32'd0);
    check("rst_rdata",  rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW aligned, ack first REQ cycle
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    check("lw_stall", 32'(stall_cnt), 32'd2);
    check("lw_be",    32'(s_be), 32'h0000000F);
    check("lw_addr",  s_addr, 32'h100);
    check("lw_we",    32'(s_we), 32'd0);
    check("lw_rvld",  32'(o_rvld), 32'd1);
    check("lw_rdata", o_rdata, 32'hDEADBEEF);
    check("lw_rvld_drop", 32'(rdata_valid), 32'd0);
    check("lw_rdata_hold", rdata, 32'hDEADBEEF);

    // LB / LBU top byte
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000);
    check("lb_be",    32'(s_be), 32'h8);
    check("lb_addr",  s_addr, 32'h100);
    check("lb_rdata", o_rdata, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80000000);
    check("lbu_rdata", o_rdata, 32'h00000080);

    // SH upper half, three wait cycles; rdata keeps the LBU result
    run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0);
    check("sh_we",    32'(s_we), 32'd1);
    check("sh_be",    32'(s_be), 32'hC);
    check("sh_addr",  s_addr, 32'h200);
    check("sh_wdata", s_wdata, 32'hABCDABCD);
    check("sh_stall", 32'(stall_cnt), 32'd5);
    check("sh_rvld",  32'(o_rvld), 32'd0);
    check("sh_rdata_hold", rdata, 32'h00000080);

    // SB lane 1 and LH/LHU upper half
    run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h0000005A, 1, 32'h0);
    check("sb_be",    32'(s_be), 32'h2);
    check("sb_wdata", s_wdata, 32'h5A5A5A5A);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80010000);
    check("lh_rdata", o_rdata, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80010000);
    check("lhu_rdata", o_rdata, 32'h00008001);
    check("lhu_stall", 32'(stall_cnt), 32'd4);

    // misaligned word load
    run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
    check("mis_req",   32'(req_cnt), 32'd0);
    check("mis_stall", 32'(stall_cnt), 32'd1);
    check("mis_exc",   32'(o_exc), 32'd1);
    check("mis_cause", 32'(o_cause), 32'h1);
    check("mis_exc_1cyc", 32'(o_exc_after), 32'd0);

    // store with an unsigned size, and a reserved size on a load
    run_op(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 0, 32'h0);
    check("bsz_st_req",   32'(req_cnt), 32'd0);
    check("bsz_st_cause", {30'd0, o_cause}, 32'h2);
    run_op(1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 0, 32'h0);
    check("bsz_ld_cause", {30'd0, o_cause}, 32'h2);

    // watchdog: no ack ever
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1000, 32'h0);
    check("to_req_cnt", 32'(req_cnt), 32'd4);
    check("to_exc",     32'(o_exc), 32'd1);
    check("to_cause",   32'(o_cause), 32'h3);
    check("to_idle_req", 32'(bus_req), 32'd0);
    // back in IDLE: a fresh access is accepted
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h11223344);
    check("to_recover", o_rdata, 32'h11223344);

    // stray ack in IDLE does nothing
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("stray_ack_rvld",  32'(rdata_valid), 32'd0);
    check("stray_ack_stall", 32'(stall), 32'd0);

    // hlt alongside a store: store finishes first, then halt
    mem_valid = 1'b1; memwrite = 1'b1; memsize = 3'b010;
    addr = 32'h300; wdata = 32'hCAFEF00D; hlt = 1'b1;
    #1;
    check("hlt_st_stall", 32'(stall), 32'd1);
    tick();
    check("hlt_st_req",    32'(bus_req), 32'd1);
    check("hlt_st_wdata",  bus_wdata, 32'hCAFEF00D);
    check("hlt_st_nohalt", 32'(halted), 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("hlt_done_stall", 32'(stall), 32'd0);
    check("hlt_done_halt",  32'(halted), 32'd0);
    mem_valid = 1'b0; memwrite = 1'b0;
    tick();
    tick();
    check("halted",      32'(halted), 32'd1);
    check("halt_stall",  32'(stall), 32'd1);
    mem_valid = 1'b1; memtoreg = 1'b1;
    tick();
    tick();
    check("halt_sticky",  32'(halted), 32'd1);
    check("halt_no_req",  32'(bus_req), 32'd0);
    clear_inputs();

    // async reset mid-REQ
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    mem_valid = 1'b1; memtoreg = 1'b1; memsize = 3'b010; addr = 32'h500;
    tick();
    check("rstreq_req", 32'(bus_req), 32'd1);
    #2;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rstreq_drop",  32'(bus_req), 32'd0);
    check("rstreq_stall", 32'(stall), 32'd0);
    check("rstreq_halt",  32'(halted), 32'd0);
    check("rstreq_bus",   bus_addr | {28'd0, bus_be}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("rstreq_noexc", {30'd0, mem_exc, rdata_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
